// File: rtl/alarma_controlador.sv
// Vehicle alarm controller: arming/disarming FSM with exit, entry and siren timers,
// registered siren output and a saturating count of trigger events.
module alarma_controlador #(
    parameter int ANCHO_CONT = 8,
    parameter int T_ARMADO   = 16,
    parameter int T_ENTRADA  = 8,
    parameter int T_SIRENA   = 32
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       sLuz,
    input  logic       sPrta,
    input  logic       sIgn,
    input  logic       cArmar,
    input  logic       cDesarmar,
    output logic       sAlr,
    output logic [2:0] estado,
    output logic [3:0] nDisparos
);

    typedef enum logic [2:0] {
        DESARMADA = 3'd0,
        ARMANDO   = 3'd1,
        ARMADA    = 3'd2,
        RETARDO   = 3'd3,
        DISPARO   = 3'd4
    } estado_e;

    // Terminal counts: a phase ends on the cycle its counter reaches T-1.
    localparam logic [ANCHO_CONT-1:0] FIN_ARMADO  = ANCHO_CONT'(T_ARMADO - 1);
    localparam logic [ANCHO_CONT-1:0] FIN_ENTRADA = ANCHO_CONT'(T_ENTRADA - 1);
    localparam logic [ANCHO_CONT-1:0] FIN_SIRENA  = ANCHO_CONT'(T_SIRENA - 1);

    estado_e               estado_q, estado_d;
    logic [ANCHO_CONT-1:0] cont_q, cont_d;
    logic                  salr_q, salr_d;
    logic [3:0]            ndisp_q, ndisp_d;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado_q <= DESARMADA;
            cont_q   <= '0;
            salr_q   <= 1'b0;
            ndisp_q  <= 4'd0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            salr_q   <= salr_d;
            ndisp_q  <= ndisp_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            DESARMADA: begin
                if (cArmar && !cDesarmar && !sIgn) estado_d = ARMANDO;
            end
            ARMANDO: begin
                if (cDesarmar || sIgn)          estado_d = DESARMADA;
                else if (cont_q == FIN_ARMADO)  estado_d = ARMADA;
            end
            ARMADA: begin
                if (cDesarmar)                  estado_d = DESARMADA;
                else if (sPrta)                 estado_d = RETARDO;
            end
            RETARDO: begin
                if (cDesarmar)                  estado_d = DESARMADA;
                else if (cont_q == FIN_ENTRADA) estado_d = DISPARO;
            end
            DISPARO: begin
                if (cDesarmar)                  estado_d = DESARMADA;
                else if (cont_q == FIN_SIRENA)  estado_d = ARMADA;
            end
            default: estado_d = DESARMADA;
        endcase
    end

    // Counter restarts on every state change and only runs in the timed states.
    always_comb begin
        cont_d = '0;
        if (estado_d == estado_q &&
            (estado_q == ARMANDO || estado_q == RETARDO || estado_q == DISPARO)) begin
            cont_d = cont_q + ANCHO_CONT'(1);
        end
    end

    always_comb begin
        ndisp_d = ndisp_q;
        if (estado_d == DISPARO && estado_q != DISPARO && ndisp_q != 4'd15) begin
            ndisp_d = ndisp_q + 4'd1;
        end
        salr_d = (estado_d == DISPARO) ||
                 (estado_d == DESARMADA && sLuz && sPrta && !sIgn);
    end

    assign sAlr      = salr_q;
    assign estado    = estado_q;
    assign nDisparos = ndisp_q;

endmodule

// File: tb/tb_alarma_controlador.sv
// Scoreboard bench for alarma_controlador: directed vectors push hand-computed
// expectations tagged with the cycle they apply to; a monitor checks them.
module tb_alarma_controlador;

    logic       clk;
    logic       reset_L;
    logic       sLuz, sPrta, sIgn, cArmar, cDesarmar;
    logic       sAlr;
    logic [2:0] estado;
    logic [3:0] nDisparos;

    typedef struct {
        int unsigned tag;
        logic [2:0]  est;
        logic        alr;
        logic [3:0]  nd;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          nTests;
    int          nFail;

    alarma_controlador dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .sLuz      (sLuz),
        .sPrta     (sPrta),
        .sIgn      (sIgn),
        .cArmar    (cArmar),
        .cDesarmar (cDesarmar),
        .sAlr      (sAlr),
        .estado    (estado),
        .nDisparos (nDisparos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [2:0] est,
                               input logic alr, input logic [3:0] nd);
        nTests = nTests + 1;
        if (estado !== est || sAlr !== alr || nDisparos !== nd) begin
            nFail = nFail + 1;
            $display("[TB] FAIL %s @cyc %0d: got estado=%0d sAlr=%b nDisparos=%0d, expected estado=%0d sAlr=%b nDisparos=%0d",
                     name, cyc, estado, sAlr, nDisparos, est, alr, nd);
        end
    endtask

    // Monitor: every falling edge, consume the expectations due for this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            checkOutput(e.name, e.est, e.alr, e.nd);
        end
    end

    // Drive inputs just after a rising edge; expectation applies after the next edge.
    task automatic applyStimulus(input logic luz, input logic prta, input logic ign,
                                 input logic arm, input logic des,
                                 input logic [2:0] est, input logic alr,
                                 input logic [3:0] nd, input string name);
        exp_t e;
        sLuz = luz; sPrta = prta; sIgn = ign; cArmar = arm; cDesarmar = des;
        e.tag = cyc + 1; e.est = est; e.alr = alr; e.nd = nd; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] ndExp;
        nTests = 0; nFail = 0; cyc = 0;
        reset_L = 1'b0;
        sLuz = 0; sPrta = 0; sIgn = 0; cArmar = 0; cDesarmar = 0;
        #12;
        checkOutput("reset_state", 3'd0, 1'b0, 4'd0);
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        #1;

        // Disarmed light warning
        applyStimulus(1, 1, 0, 0, 0, 3'd0, 1'b1, 4'd0, "luz_aviso_on");
        applyStimulus(1, 1, 0, 0, 0, 3'd0, 1'b1, 4'd0, "luz_aviso_hold");
        applyStimulus(1, 1, 1, 0, 0, 3'd0, 1'b0, 4'd0, "luz_aviso_ign");
        applyStimulus(0, 0, 1, 1, 0, 3'd0, 1'b0, 4'd0, "armar_con_ign");
        applyStimulus(0, 0, 0, 1, 1, 3'd0, 1'b0, 4'd0, "armar_y_desarmar");
        applyStimulus(1, 1, 0, 1, 1, 3'd0, 1'b1, 4'd0, "armar_y_desarmar_luz");

        // Arming window of 16 cycles
        applyStimulus(0, 0, 0, 1, 0, 3'd1, 1'b0, 4'd0, "armando_entra");
        for (int i = 0; i < 15; i++)
            applyStimulus(0, 0, 0, 0, 0, 3'd1, 1'b0, 4'd0, "armando_espera");
        applyStimulus(0, 0, 0, 0, 0, 3'd2, 1'b0, 4'd0, "armada_entra");
        applyStimulus(0, 0, 0, 0, 0, 3'd2, 1'b0, 4'd0, "armada_hold");

        // Door pulse: 8 cycles entry delay, then 32 cycles of siren
        applyStimulus(0, 1, 0, 0, 0, 3'd3, 1'b0, 4'd0, "retardo_entra");
        for (int i = 0; i < 7; i++)
            applyStimulus(0, 0, 0, 0, 0, 3'd3, 1'b0, 4'd0, "retardo_espera");
        applyStimulus(0, 0, 0, 0, 0, 3'd4, 1'b1, 4'd1, "disparo_entra");
        for (int i = 0; i < 31; i++)
            applyStimulus(0, 0, 0, 0, 0, 3'd4, 1'b1, 4'd1, "disparo_sirena");
        applyStimulus(0, 0, 0, 0, 0, 3'd2, 1'b0, 4'd1, "rearme_auto");

        // Disarm during entry delay
        applyStimulus(0, 1, 0, 0, 0, 3'd3, 1'b0, 4'd1, "retardo2_entra");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 0, 0, 0, 3'd3, 1'b0, 4'd1, "retardo2_espera");
        applyStimulus(0, 0, 0, 0, 1, 3'd0, 1'b0, 4'd1, "desarmar_retardo");

        // Re-arm, then door held open for repeated triggers until saturation
        applyStimulus(0, 0, 0, 1, 0, 3'd1, 1'b0, 4'd1, "armando2_entra");
        for (int i = 0; i < 15; i++)
            applyStimulus(0, 0, 0, 0, 0, 3'd1, 1'b0, 4'd1, "armando2_espera");
        applyStimulus(0, 1, 0, 0, 0, 3'd2, 1'b0, 4'd1, "armada_con_puerta");
        for (int k = 2; k <= 17; k++) begin
            ndExp = (k > 15) ? 4'd15 : 4'(k);
            applyStimulus(0, 1, 0, 0, 0, 3'd3, 1'b0, 4'(k - 1 > 15 ? 15 : k - 1), "sat_retardo");
            for (int i = 0; i < 7; i++)
                applyStimulus(0, 1, 0, 0, 0, 3'd3, 1'b0, 4'(k - 1 > 15 ? 15 : k - 1), "sat_retardo_espera");
            applyStimulus(0, 1, 0, 0, 0, 3'd4, 1'b1, ndExp, "sat_disparo");
            for (int i = 0; i < 31; i++)
                applyStimulus(0, 1, 0, 0, 0, 3'd4, 1'b1, ndExp, "sat_sirena");
            applyStimulus(0, 1, 0, 0, 0, 3'd2, 1'b0, ndExp, "sat_rearme");
        end

        // One more trigger, then asynchronous reset in the middle of the siren
        applyStimulus(0, 1, 0, 0, 0, 3'd3, 1'b0, 4'd15, "final_retardo");
        for (int i = 0; i < 7; i++)
            applyStimulus(0, 0, 0, 0, 0, 3'd3, 1'b0, 4'd15, "final_retardo_espera");
        applyStimulus(0, 0, 0, 0, 0, 3'd4, 1'b1, 4'd15, "final_disparo_sat");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 0, 3'd4, 1'b1, 4'd15, "final_sirena");
        @(negedge clk);
        #1;
        reset_L = 1'b0;
        #1;
        checkOutput("reset_async_disparo", 3'd0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 3'd0, 1'b0, 4'd0);
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 3'd0, 1'b0, 4'd0, "post_reset_idle");
        applyStimulus(0, 0, 0, 1, 0, 3'd1, 1'b0, 4'd0, "post_reset_armar");

        @(negedge clk);
        #1;
        nTests = nTests + 1;
        if (sb.size() != 0) begin
            nFail = nFail + 1;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
